spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning the number of 8-bit registers (fixed at 8; address width 3).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk, cs_n and mosi.
REQ-003 clk  input  1  system clock; must run at least 8x the sclk frequency.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MODE  input  2  SPI mode {CPOL,CPHA}; held static while cs_n is low.
REQ-006 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-007 cs_n  input  1  active-low chip select.
REQ-008 mosi  input  1  serial data from the master, MSB first.
REQ-009 miso  output  1  serial data to the master, MSB first.
REQ-010 miso_oe  output  1  MISO drive enable, high while synchronized cs_n is low.
REQ-011 host_we, host_addr[2:0], host_wdata[7:0]  input  host-side register write port.
REQ-012 host_addr also drives host_rdata[7:0]  output  combinational read of reg[host_addr].
REQ-013 wr_strobe  output  1  one-cycle pulse when an SPI write commits.
REQ-014 wr_addr[2:0] and wr_data[7:0]  output  address and data of the last SPI write.

Function
REQ-015 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flip-flops; sclk edges SHALL be detected on the synchronized signal.
REQ-016 Sample edge SHALL be rising sclk for MODE 0 and 3, and falling sclk for MODE 1 and 2; the shift edge SHALL be the opposite edge.
REQ-017 Transaction format: byte 0 is the command, with bit7 = R/W (1 = read), bits 6:3 ignored and bits 2:0 = address; byte 1 is data.
REQ-018 FSM states SHALL be IDLE, CMD, DATA and IGNORE.
REQ-019 IDLE -> CMD on a synchronized cs_n falling edge; the bit counter SHALL clear to 0.
REQ-020 CMD -> DATA after the 8th sample edge; on that cycle, for a read, reg[addr] SHALL load the TX shifter.
REQ-021 DATA -> IGNORE after the 8th sample edge; on that cycle, for a write, reg[addr] <= rx byte, wr_strobe = 1, and wr_addr/wr_data are updated.
REQ-022 IGNORE SHALL hold miso = 0 and discard further bits until cs_n rises.
REQ-023 A synchronized cs_n rising edge in any state SHALL return to IDLE; a partial byte SHALL be discarded with no register change and no wr_strobe.
REQ-024 For CPHA=0, the first MISO bit of each byte SHALL be valid before the first sample edge: at cs_n fall for byte 0, and at the CMD->DATA transition for byte 1.
REQ-025 For CPHA=1, MISO SHALL update on each shift edge, including the first.
REQ-026 During CMD, miso SHALL be 0.
REQ-027 During a write DATA phase, miso SHALL echo 0.
REQ-028 If host_we and an SPI commit target the same register in the same cycle, the SPI write SHALL win; for different registers, both SHALL occur.
REQ-029 The host_rdata value SHALL reflect an SPI commit on the cycle after wr_strobe.
REQ-030 An address >= NREG is impossible (NREG = 8); a read of any register SHALL return its current contents.

Reset
REQ-031 reset SHALL asynchronously clear: all registers to 8'h00, FSM to IDLE, bit counter to 0, shifters to 0, miso to 0, miso_oe to 0, wr_strobe to 0, wr_addr to 0 and wr_data to 0.
REQ-032 Synchronizer flops SHALL reset to the idle levels cs_n = 1 and mosi = 0; sclk SHALL reset to MODE[1] (CPOL) so that no false edge is detected on reset release.
REQ-033 Reset asserted mid-transaction SHALL abort with no write; after release, the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum, the MODE encodings, the command field positions (RW_BIT = 7, ADDR_LSB = 0, ADDR_W = 3) and the byte width.
REQ-035 Sub-module spi_sync_edge SHALL implement the synchronizer plus rise/fall detect, instantiated for sclk and cs_n.
REQ-036 mosi SHALL be synchronized only; it needs no edge detect.

Verification
REQ-037 MODE 0: write cmd 8'h05, data 8'hA5 -> wr_strobe pulses once; wr_addr = 5; reg[5] = A5; host_rdata(5) = A5.
REQ-038 MODE 3: host writes reg[2] = 8'h3C, then SPI read cmd 8'h82 -> master receives 8'h3C on byte 1 and 8'h00 on byte 0.
REQ-039 MODE 1 and MODE 2: repeat the write/read of 8'h5A at address 7 -> readback is 8'h5A in both modes.
REQ-040 Abort: cs_n rises after 4 data bits of a write to reg[1] -> no wr_strobe; reg[1] is unchanged; the next transaction works.
REQ-041 Collision: host_we writes reg[4] = 8'h11 on the same cycle as an SPI commit of 8'h22 to reg[4] -> reg[4] = 8'h22.
REQ-042 Reset mid-CMD, followed by a 3-byte write 8'h03/8'hFF/8'h00 -> all registers are 0 after reset; then reg[3] = FF and the third byte is ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register slave: FSM states, SPI mode
// encodings and command byte field positions.
package spi_pkg;

    localparam int BYTE_W   = 8;
    localparam int RW_BIT   = 7;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 3;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_IGNORE
    } spi_state_t;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on falling.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        logic r;
        case (mode)
            MODE_0, MODE_3: r = 1'b1;
            MODE_1, MODE_2: r = 1'b0;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized level.
// rst_val sets the post-reset level so no spurious edge appears on release.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{rst_val}};
            prev_r <= rst_val;
        end else begin
            sync_r <= (sync_r << 1) | STAGES'(d);
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave exposing an 8 x 8-bit register file: byte 0 is {rw, -, addr},
// byte 1 is data; further bytes are discarded until chip select rises.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int NREG        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        MODE,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [BYTE_W-1:0] host_wdata,
    output logic [BYTE_W-1:0] host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output spi_state_t        dbg_state
);

    localparam int CNT_W = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic                   sample_edge, shift_edge, cpha;

    spi_state_t             state, state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BYTE_W-2:0]      rx_sh;
    logic [BYTE_W-1:0]      rx_full, tx_sh, rd_byte;
    logic                   cmd_rw;
    logic [ADDR_W-1:0]      cmd_addr, rx_addr;
    logic                   byte_done, cmd_done, data_done, commit;
    logic [BYTE_W-1:0]      regs [NREG];

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .rst_val(MODE[1]), .d(sclk),
        .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .rst_val(1'b1), .d(cs_n),
        .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mosi_sync <= '0;
        else       mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
    end

    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cpha        = MODE[0];
    assign sample_edge = sample_on_rise(MODE) ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_on_rise(MODE) ? sclk_fall : sclk_rise;
    assign rx_full     = {rx_sh, mosi_s};
    assign rx_addr     = rx_full[ADDR_LSB +: ADDR_W];
    assign rd_byte     = regs[rx_addr];
    assign host_rdata  = regs[host_addr];
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // A chip-select release always wins, so a byte completing on the same
    // cycle is treated as partial and dropped.
    always_comb begin
        state_next = state;
        byte_done  = sample_edge && (bit_cnt == LAST_BIT) && !cs_rise;
        cmd_done   = 1'b0;
        data_done  = 1'b0;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (cs_fall) state_next = ST_CMD;
                ST_CMD:    if (byte_done) begin
                               state_next = ST_DATA;
                               cmd_done   = 1'b1;
                           end
                ST_DATA:   if (byte_done) begin
                               state_next = ST_IGNORE;
                               data_done  = 1'b1;
                           end
                ST_IGNORE: state_next = ST_IGNORE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign commit = data_done && !cmd_rw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (cs_fall)      miso_oe <= 1'b1;
            else if (cs_rise) miso_oe <= 1'b0;

            // Host port first so a same-register SPI commit below overrides it.
            if (host_we) regs[host_addr] <= host_wdata;

            if (cs_rise || (state == ST_IDLE && cs_fall)) begin
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= '0;
                miso    <= 1'b0;
            end else if (state == ST_CMD) begin
                if (sample_edge) begin
                    rx_sh   <= rx_full[BYTE_W-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (cmd_done) begin
                    cmd_rw   <= rx_full[RW_BIT];
                    cmd_addr <= rx_addr;
                    // CPHA=0 must present the data MSB before its first sample edge.
                    if (rx_full[RW_BIT] && !cpha) begin
                        miso  <= rd_byte[BYTE_W-1];
                        tx_sh <= {rd_byte[BYTE_W-2:0], 1'b0};
                    end else if (rx_full[RW_BIT]) begin
                        tx_sh <= rd_byte;
                    end else begin
                        tx_sh <= '0;
                    end
                end
            end else if (state == ST_DATA) begin
                if (sample_edge) begin
                    rx_sh   <= rx_full[BYTE_W-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (data_done) begin
                    miso <= 1'b0;
                    if (commit) begin
                        regs[cmd_addr] <= rx_full;
                        wr_strobe      <= 1'b1;
                        wr_addr        <= cmd_addr;
                        wr_data        <= rx_full;
                    end
                end else if (shift_edge && cmd_rw && (cpha || bit_cnt != '0)) begin
                    miso  <= tx_sh[BYTE_W-1];
                    tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
                end
            end else if (state == ST_IGNORE) begin
                miso <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed transaction table, randomized traffic
// against a register-array model, collision and reset-abort sequences.
module tb_spi_reg_slave;
    import spi_pkg::*;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic       host_we;
    logic [2:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    spi_state_t dbg_state;

    spi_reg_slave #(.NREG(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .MODE(mode), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int bits_sent = 0;
    int oe_bad = 0;
    int strobe_cnt = 0;
    logic [2:0] mon_addr;
    logic [7:0] mon_data, mon_rdata;
    logic [7:0] exp_regs [8];
    logic [7:0] r0, r1, r2;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] cmd;
        logic [7:0] data;
        int         nbits;
        logic [7:0] exp_rx0;
        logic [7:0] exp_rx1;
        int         exp_strobes;
        logic [2:0] chk_addr;
        logic [7:0] exp_reg;
    } vec_t;

    vec_t vecs [12];

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            mon_addr   = wr_addr;
            mon_data   = wr_data;
            mon_rdata  = host_rdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        @(negedge clk);
        host_we    = 1'b0;
        exp_regs[a] = d;
    endtask

    task automatic spi_begin(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic spi_bit(input logic [1:0] m, input logic tb, output logic rb);
        if (!m[0]) begin
            mosi = tb;
            #(HALF);
            rb = miso;
            if (!miso_oe) oe_bad++;
            sclk = ~sclk;
            #(HALF);
            sclk = ~sclk;
        end else begin
            sclk = ~sclk;
            mosi = tb;
            #(HALF);
            rb = miso;
            if (!miso_oe) oe_bad++;
            sclk = ~sclk;
            #(HALF);
        end
        bits_sent++;
    endtask

    task automatic spi_end();
        #(HALF);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [1:0] m, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int nbits,
                            output logic [7:0] o0, output logic [7:0] o1, output logic [7:0] o2);
        logic [23:0] tx;
        logic [23:0] rx;
        logic        rb;
        tx = {b0, b1, b2};
        rx = '0;
        spi_begin(m);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(m, tx[23-i], rb);
            rx[23-i] = rb;
        end
        spi_end();
        o0 = rx[23:16];
        o1 = rx[15:8];
        o2 = rx[7:0];
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        host_addr = a;
        #1;
        check(name, host_rdata, exp);
    endtask

    // model of one complete/partial transaction applied to exp_regs
    task automatic model_apply(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
        if (nbits >= 16 && !cmd[7]) exp_regs[cmd[2:0]] = data;
    endtask

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic collide(input logic [2:0] h_addr, input logic [7:0] h_data,
                           input logic [7:0] spi_data, input string tag);
        int start;
        int n;
        int sc0;
        start = bits_sent;
        sc0   = strobe_cnt;
        fork
            spi_xfer(2'd0, 8'h04, spi_data, 8'h00, 16, r0, r1, r2);
            begin
                n = 0;
                while (bits_sent < start + 15 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                host_addr  = h_addr;
                host_wdata = h_data;
                host_we    = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wr_strobe && n < 200);
                host_we = 1'b0;
                check({tag, "_strobe_seen"}, (n < 200), 1);
            end
        join
        check({tag, "_strobes"}, strobe_cnt - sc0, 1);
        exp_regs[h_addr] = h_data;
        exp_regs[4]      = spi_data;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        failures++;
        report();
        $finish;
    end

    initial begin
        logic [1:0] m;
        logic       rw;
        logic [2:0] a;
        logic [7:0] d, cmd, b2, exp_rx1;
        int         nb, sel, sc0;

        reset = 1'b1; mode = 2'd0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        for (int i = 0; i < 8; i++) read_check($sformatf("rst_reg%0d", i), 3'(i), 8'h00);

        host_write(3'd2, 8'h3C);

        vecs[0]  = '{2'd0, 8'h05, 8'hA5, 16, 8'h00, 8'h00, 1, 3'd5, 8'hA5};
        vecs[1]  = '{2'd3, 8'h82, 8'h00, 16, 8'h00, 8'h3C, 0, 3'd2, 8'h3C};
        vecs[2]  = '{2'd1, 8'h07, 8'h5A, 16, 8'h00, 8'h00, 1, 3'd7, 8'h5A};
        vecs[3]  = '{2'd1, 8'h87, 8'h00, 16, 8'h00, 8'h5A, 0, 3'd7, 8'h5A};
        vecs[4]  = '{2'd0, 8'h07, 8'h00, 16, 8'h00, 8'h00, 1, 3'd7, 8'h00};
        vecs[5]  = '{2'd2, 8'h07, 8'h5A, 16, 8'h00, 8'h00, 1, 3'd7, 8'h5A};
        vecs[6]  = '{2'd2, 8'h87, 8'hFF, 16, 8'h00, 8'h5A, 0, 3'd7, 8'h5A};
        vecs[7]  = '{2'd0, 8'h01, 8'hF0, 12, 8'h00, 8'h00, 0, 3'd1, 8'h00};
        vecs[8]  = '{2'd0, 8'h01, 8'h6E, 16, 8'h00, 8'h00, 1, 3'd1, 8'h6E};
        vecs[9]  = '{2'd3, 8'h85, 8'h00, 16, 8'h00, 8'hA5, 0, 3'd5, 8'hA5};
        vecs[10] = '{2'd0, 8'hFA, 8'h00, 16, 8'h00, 8'h3C, 0, 3'd2, 8'h3C};
        vecs[11] = '{2'd1, 8'h7B, 8'hC3, 16, 8'h00, 8'h00, 1, 3'd3, 8'hC3};

        for (int i = 0; i < 12; i++) begin
            host_addr = vecs[i].chk_addr;
            sc0    = strobe_cnt;
            oe_bad = 0;
            spi_xfer(vecs[i].mode, vecs[i].cmd, vecs[i].data, 8'h00, vecs[i].nbits, r0, r1, r2);
            model_apply(vecs[i].cmd, vecs[i].data, vecs[i].nbits);
            check($sformatf("v%0d_rx0", i), r0, vecs[i].exp_rx0);
            if (vecs[i].nbits >= 16) check($sformatf("v%0d_rx1", i), r1, vecs[i].exp_rx1);
            check($sformatf("v%0d_strobes", i), strobe_cnt - sc0, vecs[i].exp_strobes);
            if (vecs[i].exp_strobes == 1) begin
                check($sformatf("v%0d_wr_addr", i), mon_addr, vecs[i].chk_addr);
                check($sformatf("v%0d_wr_data", i), mon_data, vecs[i].exp_reg);
                check($sformatf("v%0d_rdata_after_strobe", i), mon_rdata, vecs[i].exp_reg);
            end
            check($sformatf("v%0d_oe_during", i), oe_bad, 0);
            check($sformatf("v%0d_oe_after", i), miso_oe, 0);
            check($sformatf("v%0d_state_after", i), 32'(dbg_state), 32'(ST_IDLE));
            read_check($sformatf("v%0d_reg", i), vecs[i].chk_addr, vecs[i].exp_reg);
        end

        // randomized traffic against the register-array model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) host_write(3'($urandom_range(0, 7)), 8'($urandom));
            m   = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            b2  = 8'($urandom);
            sel = $urandom_range(0, 9);
            nb  = (sel == 0) ? $urandom_range(1, 15) : (sel == 1) ? 24 : 16;
            cmd = {rw, 4'($urandom), a};
            exp_rx1 = rw ? exp_regs[a] : 8'h00;
            host_addr = a;
            sc0 = strobe_cnt;
            spi_xfer(m, cmd, d, b2, nb, r0, r1, r2);
            check($sformatf("r%0d_rx0", i), r0, 8'h00);
            if (nb >= 16 || !rw) check($sformatf("r%0d_rx1", i), r1, exp_rx1);
            if (nb == 24) check($sformatf("r%0d_rx2", i), r2, 8'h00);
            check($sformatf("r%0d_strobes", i), strobe_cnt - sc0, (nb >= 16 && !rw) ? 1 : 0);
            model_apply(cmd, d, nb);
            read_check($sformatf("r%0d_reg", i), a, exp_regs[a]);
        end
        for (int i = 0; i < 8; i++) read_check($sformatf("rand_final_reg%0d", i), 3'(i), exp_regs[i]);

        // host and SPI writing the same register on the commit cycle
        collide(3'd4, 8'h11, 8'h22, "coll_same");
        read_check("coll_same_reg4", 3'd4, 8'h22);
        check("coll_same_rdata_at_strobe", mon_rdata, 8'h22);
        collide(3'd6, 8'h77, 8'h33, "coll_diff");
        read_check("coll_diff_reg4", 3'd4, 8'h33);
        read_check("coll_diff_reg6", 3'd6, 8'h77);

        // reset in the middle of the command byte
        spi_begin(2'd0);
        for (int i = 0; i < 4; i++) spi_bit(2'd0, i[0], mosi);
        reset = 1'b1;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_wr_strobe", wr_strobe, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_miso_oe", miso_oe, 0);
        for (int i = 0; i < 8; i++) read_check($sformatf("midrst_reg%0d", i), 3'(i), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("postrst_state", 32'(dbg_state), 32'(ST_IDLE));

        sc0 = strobe_cnt;
        host_addr = 3'd3;
        spi_xfer(2'd0, 8'h03, 8'hFF, 8'h00, 24, r0, r1, r2);
        model_apply(8'h03, 8'hFF, 24);
        check("three_byte_strobes", strobe_cnt - sc0, 1);
        check("three_byte_rx2", r2, 8'h00);
        check("three_byte_wr_addr", mon_addr, 3);
        for (int i = 0; i < 8; i++) read_check($sformatf("three_byte_reg%0d", i), 3'(i), exp_regs[i]);

        report();
        $finish;
    end

endmodule
